// File: rtl/diff_core_pkg.sv
// Shared definitions for the diff core write-back path.
//
// Contents:
//   CONF_GUARD_W  outputs covered by one guard word
//   wb_state_e    write-back transmitter FSM encoding
//   wb_requant    round-half-up arithmetic right shift, optional ReLU, and
//                 saturation to signed 8 bits
package diff_core_pkg;

  localparam int CONF_GUARD_W = 6;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_RUN   = 2'd1,
    WB_DRAIN = 2'd2
  } wb_state_e;

  // The caller sign-extends the accumulator to 32 bits. The arithmetic is
  // done one bit wider than that, so the rounding add can never overflow for
  // any accumulator width up to 32.
  function automatic logic signed [7:0] wb_requant(
    input logic signed [31:0] acc,
    input logic        [3:0]  shift,
    input logic               relu
  );
    logic signed [32:0] wide;
    logic signed [32:0] rnd;
    logic signed [32:0] r;
    wide = {acc[31], acc};
    rnd  = 33'sd1 <<< (shift - 4'd1);
    if (shift == 4'd0) r = wide;
    else               r = (wide + rnd) >>> shift;
    if (relu && (r < 33'sd0)) r = 33'sd0;
    if (r > 33'sd127)         return 8'sh7f;
    else if (r < -33'sd128)   return 8'sh80;
    else                      return r[7:0];
  endfunction

endpackage

// File: rtl/pe_row_wb_tx_fifo.sv
// wb_sync_fifo: single-clock FIFO carrying the quantized output bytes.
//
// Ports:
//   clk, rst     core clock, asynchronous active-high reset
//   push, din    write an entry (ignored when full)
//   pop          drop the head entry (ignored when empty)
//   dout         head entry, reads as 0 while empty
//   count        registered occupancy
//   full, empty  derived from the registered occupancy
module wb_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_q;
  assign dout    = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until the pointers say so.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pe_row_wb_tx.sv
// pe_row_wb_tx: write-back transmitter at the bottom of one PE row.
// It requantizes accumulator results to 8 bits, queues them for the fm
// buffer, and builds one nonzero guard map for every GUARD_W outputs.
//
// Build option: WB_ZERO_SKIP_EN -- results that quantize to 0 are left out of
// the fm stream. Their guard bit (0) is then the only record of them.
//
// Ports:
//   clk, rst                    core clock, asynchronous active-high reset
//   start, cfg_shift, cfg_relu_en   begin a row; cfg is latched in IDLE
//   acc_valid/acc_ready/acc_data/acc_last   accumulator input stream
//   fm_write_back_data(_o_valid), fm_buf_ready   quantized output stream
//   guard_o(_valid), guard_buf_ready             guard word stream
//   busy        FSM is not idle
//   row_done    one-cycle pulse on the DRAIN -> IDLE transition
//   dbg_state   current FSM state (wb_state_e encoding)
//
// Handshake: each stream transfers on a rising edge where valid and ready are
// both high. A source keeps valid and its data stable until that transfer.
// acc_ready does not look at acc_valid.
module pe_row_wb_tx
  import diff_core_pkg::*;
#(
  parameter int ACC_W         = 20,
  parameter int WB_FIFO_DEPTH = 4,
  parameter int GUARD_W       = CONF_GUARD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         cfg_shift,
  input  logic               cfg_relu_en,
  input  logic               acc_valid,
  output logic               acc_ready,
  input  logic [ACC_W-1:0]   acc_data,
  input  logic               acc_last,
  output logic [7:0]         fm_write_back_data,
  output logic               fm_write_back_data_o_valid,
  input  logic               fm_buf_ready,
  output logic [GUARD_W-1:0] guard_o,
  output logic               guard_o_valid,
  input  logic               guard_buf_ready,
  output logic               busy,
  output logic               row_done,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'(WB_IDLE);
  localparam logic [1:0] S_RUN   = 2'(WB_RUN);
  localparam logic [1:0] S_DRAIN = 2'(WB_DRAIN);
  localparam int         GCW     = $clog2(GUARD_W);

  logic [1:0]           state_q, state_d;
  logic [3:0]           shift_q, shift_d;
  logic                 relu_q, relu_d;
  logic [GCW-1:0]       gcnt_q, gcnt_d;
  logic [GUARD_W-1:0]   shadow_q, shadow_d;
  logic [GUARD_W-1:0]   guard_q, guard_d;
  logic                 guard_valid_q, guard_valid_d;

  logic                 accept, group_end, guard_stall, nz, push;
  logic [GUARD_W-1:0]   word;
  logic signed [31:0]   acc_ext;
  logic [7:0]           q;
  logic [$clog2(WB_FIFO_DEPTH):0] fifo_count;
  logic                 fifo_full, fifo_empty;

  assign acc_ext   = {{(32-ACC_W){acc_data[ACC_W-1]}}, acc_data};
  assign q         = wb_requant(acc_ext, shift_q, relu_q);
  assign nz        = (q != 8'd0);
  assign group_end = (gcnt_q == GCW'(GUARD_W-1)) || acc_last;

  // Only the beat that would complete a guard word has to wait for the
  // previous word; every other beat only touches the shadow map.
  assign guard_stall = guard_valid_q && !guard_buf_ready && group_end;
  assign acc_ready   = (state_q == S_RUN) && !fifo_full && !guard_stall;
  assign accept      = acc_valid && acc_ready;

`ifdef WB_ZERO_SKIP_EN
  assign push = accept && nz;
`else
  assign push = accept;
`endif

  wb_sync_fifo #(.W(8), .DEPTH(WB_FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (q),
    .pop   (fm_buf_ready),
    .dout  (fm_write_back_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    relu_d        = relu_q;
    gcnt_d        = gcnt_q;
    shadow_d      = shadow_q;
    guard_d       = guard_q;
    guard_valid_d = guard_valid_q && !guard_buf_ready;
    word          = shadow_q;
    word[gcnt_q]  = nz;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          shift_d  = cfg_shift;
          relu_d   = cfg_relu_en;
          gcnt_d   = '0;
          shadow_d = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (group_end) begin
            // Bits above gcnt are still clear in the shadow, so a short
            // final group comes out zero-padded.
            guard_d       = word;
            guard_valid_d = 1'b1;
            shadow_d      = '0;
            gcnt_d        = '0;
          end else begin
            shadow_d = word;
            gcnt_d   = gcnt_q + 1'b1;
          end
          if (acc_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty && !guard_valid_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      relu_q        <= 1'b0;
      gcnt_q        <= '0;
      shadow_q      <= '0;
      guard_q       <= '0;
      guard_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      relu_q        <= relu_d;
      gcnt_q        <= gcnt_d;
      shadow_q      <= shadow_d;
      guard_q       <= guard_d;
      guard_valid_q <= guard_valid_d;
    end
  end

  assign fm_write_back_data_o_valid = !fifo_empty;
  assign guard_o       = guard_valid_q ? guard_q : '0;
  assign guard_o_valid = guard_valid_q;
  assign busy          = (state_q != S_IDLE);
  assign row_done      = (state_q == S_DRAIN) && fifo_empty && !guard_valid_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pe_row_wb_tx.sv
// Directed testbench for pe_row_wb_tx. The expected fm bytes and guard words
// are hand-computed and queued before each row. Two monitors on the falling
// edge pop and compare every transfer.
module tb_pe_row_wb_tx;
  import diff_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cfg_shift = '0;
  logic        cfg_relu_en = 1'b0;
  logic        acc_valid = 1'b0;
  logic        acc_ready;
  logic [19:0] acc_data = '0;
  logic        acc_last = 1'b0;
  logic [7:0]  fm_write_back_data;
  logic        fm_write_back_data_o_valid;
  logic        fm_buf_ready = 1'b1;
  logic [5:0]  guard_o;
  logic        guard_o_valid;
  logic        guard_buf_ready = 1'b1;
  logic        busy;
  logic        row_done;
  logic [1:0]  dbg_state;

  pe_row_wb_tx dut (
    .clk                        (clk),
    .rst                        (rst),
    .start                      (start),
    .cfg_shift                  (cfg_shift),
    .cfg_relu_en                (cfg_relu_en),
    .acc_valid                  (acc_valid),
    .acc_ready                  (acc_ready),
    .acc_data                   (acc_data),
    .acc_last                   (acc_last),
    .fm_write_back_data         (fm_write_back_data),
    .fm_write_back_data_o_valid (fm_write_back_data_o_valid),
    .fm_buf_ready               (fm_buf_ready),
    .guard_o                    (guard_o),
    .guard_o_valid              (guard_o_valid),
    .guard_buf_ready            (guard_buf_ready),
    .busy                       (busy),
    .row_done                   (row_done),
    .dbg_state                  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_fm_q[$];
  logic [5:0] exp_gd_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int last_fm_cyc = 0;
  int row_done_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && fm_write_back_data_o_valid && fm_buf_ready) begin
      last_fm_cyc = cyc;
      if (exp_fm_q.size() == 0) check_eq("fm_unexpected_beat", 32'(fm_write_back_data), 32'hffff_ffff);
      else check_eq("fm_data", 32'(fm_write_back_data), 32'(exp_fm_q.pop_front()));
    end
    if (!rst && guard_o_valid && guard_buf_ready) begin
      if (exp_gd_q.size() == 0) check_eq("guard_unexpected", 32'(guard_o), 32'hffff_ffff);
      else check_eq("guard_word", 32'(guard_o), 32'(exp_gd_q.pop_front()));
    end
    if (row_done) row_done_cnt++;
  end

  // Expected fm byte for one accepted result; zeros drop out of the stream
  // when zero skipping is built in.
  task automatic exp_fm(input logic [7:0] qv);
`ifdef WB_ZERO_SKIP_EN
    if (qv != 8'd0) exp_fm_q.push_back(qv);
`else
    exp_fm_q.push_back(qv);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_row(input logic [3:0] sh, input logic relu);
    start = 1'b1; cfg_shift = sh; cfg_relu_en = relu;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input int val, input logic last);
    int t;
    acc_valid = 1'b1; acc_data = 20'(val); acc_last = last;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (acc_ready) break;
      t++;
      if (t > 500) begin
        check_eq("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    acc_valid = 1'b0; acc_last = 1'b0;
  endtask

  task automatic wait_row_done(input bit chk_latency);
    int t;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (row_done) break;
      t++;
      if (t > 500) begin
        check_eq("row_done_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (chk_latency) check_eq("row_done_latency", 32'(cyc - last_fm_cyc), 32'd1);
    @(posedge clk); #1;
    check_eq("busy_after_row", 32'(busy), 32'd0);
    check_eq("fm_queue_drained", 32'(exp_fm_q.size()), 32'd0);
    check_eq("guard_queue_drained", 32'(exp_gd_q.size()), 32'd0);
  endtask

  int vals[6] = '{10, 20, 30, 40, 50, 60};
  int idx, accepted, rd_before;
  bit hs;

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_fm_valid", 32'(fm_write_back_data_o_valid), 32'd0);
    check_eq("rst_fm_data", 32'(fm_write_back_data), 32'd0);
    check_eq("rst_guard_valid", 32'(guard_o_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_acc_ready", 32'(acc_ready), 32'd0);
    check_eq("rst_row_done", 32'(row_done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Row 1: shift 4, ReLU. 291->0x12, -100->0 (ReLU), 5000->0x7F (sat).
    start_row(4'd4, 1'b1);
    check_eq("state_run", 32'(dbg_state), 32'(WB_RUN));
    check_eq("busy_run", 32'(busy), 32'd1);
    exp_fm(8'h12); exp_fm(8'h00); exp_fm(8'h7f);
    exp_gd_q.push_back(6'b000101);
    send_beat(291, 1'b0);
    send_beat(-100, 1'b0);
    send_beat(5000, 1'b1);
    wait_row_done(1'b0);

    // Row 2: shift 0, no ReLU, saturation at the negative rail.
    start_row(4'd0, 1'b0);
    exp_fm(8'h80); exp_fm(8'h80); exp_fm(8'h7f);
    exp_gd_q.push_back(6'b000111);
    send_beat(-300, 1'b0);
    send_beat(-128, 1'b0);
    send_beat(127, 1'b1);
    wait_row_done(1'b0);

    // Row 3: eight nonzero results -> a full guard word then a two-bit one.
    start_row(4'd0, 1'b0);
    for (int i = 1; i <= 8; i++) exp_fm(8'(i));
    exp_gd_q.push_back(6'b111111);
    exp_gd_q.push_back(6'b000011);
    for (int i = 1; i <= 8; i++) send_beat(i, (i == 8));
    wait_row_done(1'b1);

    // Row 4: fm buffer stalled, acc_valid held -> FIFO fills after 4 accepts.
    start_row(4'd0, 1'b0);
    fm_buf_ready = 1'b0;
    idx = 0; accepted = 0;
    acc_valid = 1'b1; acc_data = 20'(vals[0]); acc_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      hs = acc_ready;
      @(posedge clk); #1;
      if (hs) begin
        exp_fm(8'(vals[idx]));
        idx++; accepted++;
        acc_data = 20'(vals[idx]); acc_last = (idx == 5);
      end
    end
    @(negedge clk);
    check_eq("stall_accepts", 32'(accepted), 32'd4);
    check_eq("stall_acc_ready", 32'(acc_ready), 32'd0);
    check_eq("stall_fm_valid", 32'(fm_write_back_data_o_valid), 32'd1);
    check_eq("stall_fm_head", 32'(fm_write_back_data), 32'd10);
    @(posedge clk); #1;
    acc_valid = 1'b0;
    fm_buf_ready = 1'b1;
    exp_fm(8'(vals[4])); exp_fm(8'(vals[5]));
    exp_gd_q.push_back(6'b111111);
    send_beat(vals[4], 1'b0);
    send_beat(vals[5], 1'b1);
    wait_row_done(1'b0);

    // Row 5: guard buffer stalled while group 2 completes.
    start_row(4'd0, 1'b0);
    guard_buf_ready = 1'b0;
    for (int i = 1; i <= 12; i++) exp_fm(8'(i));
    exp_gd_q.push_back(6'b111111);
    exp_gd_q.push_back(6'b111111);
    for (int i = 1; i <= 11; i++) send_beat(i, 1'b0);
    acc_valid = 1'b1; acc_data = 20'd12; acc_last = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("gstall_acc_ready", 32'(acc_ready), 32'd0);
    check_eq("gstall_guard_valid", 32'(guard_o_valid), 32'd1);
    check_eq("gstall_guard_word", 32'(guard_o), 32'h3f);
    @(posedge clk); #1;
    guard_buf_ready = 1'b1;
    send_beat(12, 1'b1);
    wait_row_done(1'b0);

    // Row 6: reset with three entries queued -> everything flushed, no row_done.
    start_row(4'd0, 1'b0);
    fm_buf_ready = 1'b0;
    send_beat(7, 1'b0);
    send_beat(8, 1'b0);
    send_beat(9, 1'b0);
    @(negedge clk);
    check_eq("pre_rst_fm_valid", 32'(fm_write_back_data_o_valid), 32'd1);
    rd_before = row_done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_fm_valid", 32'(fm_write_back_data_o_valid), 32'd0);
    check_eq("midrst_guard_valid", 32'(guard_o_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    fm_buf_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    check_eq("midrst_no_row_done", 32'(row_done_cnt), 32'(rd_before));
    check_eq("midrst_state_idle", 32'(dbg_state), 32'(WB_IDLE));

    // Row 7: zero results -> guard 3'b010; zeros leave the fm stream only
    // when zero skipping is built in.
    start_row(4'd0, 1'b0);
    exp_fm(8'h00); exp_fm(8'h05); exp_fm(8'h00);
    exp_gd_q.push_back(6'b000010);
    send_beat(0, 1'b0);
    send_beat(5, 1'b0);
    send_beat(0, 1'b1);
    wait_row_done(1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time limit so a wedged run still reaches a verdict.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000 ns");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
